outputc_nvc: RTL and testbench

- Parametrised successor of the router output-channel stage. It sits between the switch allocator/crossbar output and the physical link to the neighbouring router.
- Registers outgoing flits and tracks downstream buffer occupancy per virtual channel (credit counting from iack).
- Generates per-VC ready and packet-granular VC lock.
- Adds NVC channels, wormhole or virtual-cut-through ready modes, and sticky credit/protocol error flags.

---
 rtl/outputc_nvc_pkg.sv | 18 +
 rtl/outputc_vcstate.sv | 89 ++++++++
 rtl/outputc_nvc.sv | 97 +++++++++
 tb/tb_outputc_nvc.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/outputc_nvc_pkg.sv
// Shared definitions for the output-channel stage: flit-type codes and error-bit positions.
package outputc_nvc_pkg;

   localparam int unsigned TYPEW = 2;

   typedef enum logic [TYPEW-1:0] {
      FLIT_SINGLE = 2'b00,
      FLIT_HEAD   = 2'b01,
      FLIT_BODY   = 2'b10,
      FLIT_TAIL   = 2'b11
   } flit_type_e;

   localparam int unsigned ERRW      = 3;
   localparam int unsigned ERR_OVF   = 0;
   localparam int unsigned ERR_UNF   = 1;
   localparam int unsigned ERR_PROTO = 2;

endpackage

// File: rtl/outputc_vcstate.sv
// Per-VC state: downstream credit count, open-packet flag, lock and ready,
// plus single-cycle error events that the top level accumulates.
module outputc_vcstate
   import outputc_nvc_pkg::*;
#(
   parameter int unsigned FIFOD  = 4,
   parameter int unsigned PKTLEN = 4,
   parameter int unsigned MODE   = 0
) (
   input  logic       clk,
   input  logic       rst_,
   input  logic       snd,
   input  flit_type_e ftype,
   input  logic       busy,
   input  logic       iack,
   input  logic       ilck,
   output logic       ordy,
   output logic       olck,
   output logic       ovf,
   output logic       unf,
   output logic       proto
);

   localparam int unsigned CNTW = $clog2(FIFOD + 1);
   localparam logic [CNTW-1:0] CNT_MAX = CNTW'(FIFOD);
   localparam logic [CNTW-1:0] CNT_ONE = CNTW'(1);
   localparam logic [CNTW-1:0] THR = (MODE == 0) ? CNTW'(PKTLEN) : CNTW'(1);

   logic [CNTW-1:0] cnt_q, cnt_d;
   logic            open_q, open_d;
   logic            lck_q, lck_d;

   always_comb begin
      cnt_d = cnt_q;
      ovf   = 1'b0;
      unf   = 1'b0;
      if (snd && !iack) begin
         if (cnt_q == CNT_MAX) ovf = 1'b1;
         else                  cnt_d = cnt_q + CNT_ONE;
      end else if (iack && !snd) begin
         if (cnt_q == '0) unf = 1'b1;
         else             cnt_d = cnt_q - CNT_ONE;
      end
   end

   // A misplaced HEAD/SINGLE leaves the packet open; a stray TAIL leaves it closed.
   always_comb begin
      open_d = open_q;
      proto  = 1'b0;
      if (snd) begin
         case (ftype)
            FLIT_HEAD: begin
               proto  = open_q;
               open_d = 1'b1;
            end
            FLIT_SINGLE: proto = open_q;
            FLIT_BODY:   proto = !open_q;
            FLIT_TAIL: begin
               proto  = !open_q;
               open_d = 1'b0;
            end
            default: proto = 1'b0;
         endcase
      end
   end

   always_comb begin
      lck_d = lck_q;
      if (snd || busy)  lck_d = 1'b1;
      else if (open_q)  lck_d = 1'b1;
      else if (!ilck)   lck_d = 1'b0;
   end

   always_ff @(posedge clk or posedge rst_) begin
      if (rst_) begin
         cnt_q  <= '0;
         open_q <= 1'b0;
         lck_q  <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         open_q <= open_d;
         lck_q  <= lck_d;
      end
   end

   assign ordy = (CNT_MAX - cnt_q) >= THR;
   assign olck = lck_q;

endmodule

// File: rtl/outputc_nvc.sv
// Router output-channel stage: registers flits towards the link and tracks
// per-VC downstream credits, readiness and packet locks.
module outputc_nvc
   import outputc_nvc_pkg::*;
#(
   parameter int unsigned ROUTERID = 0,
   parameter int unsigned PCHID    = 0,
   parameter int unsigned NVC      = 4,
   parameter int unsigned VCHW     = 2,
   parameter int unsigned DATAW    = 64,
   parameter int unsigned TYPE_LSB = 62,
   parameter int unsigned FIFOD    = 4,
   parameter int unsigned PKTLEN   = 4,
   parameter int unsigned MODE     = 0
) (
   input  logic             clk,
   input  logic             rst_,
   input  logic [DATAW-1:0] idata,
   input  logic             ivalid,
   input  logic [VCHW-1:0]  ivch,
   output logic [DATAW-1:0] odata,
   output logic             ovalid,
   output logic [VCHW-1:0]  ovch,
   input  logic [NVC-1:0]   iack,
   output logic [NVC-1:0]   ordy,
   input  logic [NVC-1:0]   ilck,
   output logic [NVC-1:0]   olck,
   output logic [ERRW-1:0]  err
);

   // Identification parameters only; kept visible for debug.
   logic [63:0] unused_id;
   assign unused_id = {32'(ROUTERID), 32'(PCHID)};

   logic [DATAW-1:0] odata_q;
   logic             ovalid_q;
   logic [VCHW-1:0]  ovch_q;
   logic [ERRW-1:0]  err_q, err_d;

   logic [NVC-1:0] snd, busy, ovf, unf, proto;
   logic           bad_vch;
   flit_type_e     ftype;

   assign ftype   = flit_type_e'(idata[TYPE_LSB +: TYPEW]);
   assign bad_vch = ivalid && ({1'b0, ivch} >= (VCHW + 1)'(NVC));

   for (genvar v = 0; v < NVC; v++) begin : g_vc
      assign snd[v]  = ivalid && (ivch == VCHW'(v));
      assign busy[v] = ovalid_q && (ovch_q == VCHW'(v));

      outputc_vcstate #(
         .FIFOD  (FIFOD),
         .PKTLEN (PKTLEN),
         .MODE   (MODE)
      ) u_vcstate (
         .clk   (clk),
         .rst_  (rst_),
         .snd   (snd[v]),
         .ftype (ftype),
         .busy  (busy[v]),
         .iack  (iack[v]),
         .ilck  (ilck[v]),
         .ordy  (ordy[v]),
         .olck  (olck[v]),
         .ovf   (ovf[v]),
         .unf   (unf[v]),
         .proto (proto[v])
      );
   end

   always_comb begin
      err_d            = err_q;
      err_d[ERR_OVF]   = err_q[ERR_OVF] | (|ovf);
      err_d[ERR_UNF]   = err_q[ERR_UNF] | (|unf);
      err_d[ERR_PROTO] = err_q[ERR_PROTO] | (|proto) | bad_vch;
   end

   always_ff @(posedge clk or posedge rst_) begin
      if (rst_) begin
         odata_q  <= '0;
         ovalid_q <= 1'b0;
         ovch_q   <= '0;
         err_q    <= '0;
      end else begin
         odata_q  <= ivalid ? idata : '0;
         ovalid_q <= ivalid;
         ovch_q   <= ivalid ? ivch : '0;
         err_q    <= err_d;
      end
   end

   assign odata  = odata_q;
   assign ovalid = ovalid_q;
   assign ovch   = ovch_q;
   assign err    = err_q;

endmodule

// File: tb/tb_outputc_nvc.sv
// Bench for outputc_nvc: cut-through and wormhole instances share stimulus and
// are compared against a flit/credit-level reference model.
module tb_outputc_nvc;

   localparam logic [1:0] T_SINGLE = 2'b00, T_HEAD = 2'b01, T_BODY = 2'b10, T_TAIL = 2'b11;

   logic        clk, rst_;
   logic [63:0] idata;
   logic        ivalid;
   logic [1:0]  ivch;
   logic [3:0]  iack, ilck;

   logic [63:0] odata0, odata1;
   logic        ovalid0, ovalid1;
   logic [1:0]  ovch0, ovch1;
   logic [3:0]  ordy0, ordy1, olck0, olck1;
   logic [2:0]  err0, err1;

   int checks = 0;
   int errors = 0;

   // Reference model state
   int          m_cnt[4];
   bit          m_open[4];
   bit          m_olck[4];
   logic [2:0]  m_err;
   logic [63:0] m_odata;
   bit          m_ovalid;
   logic [1:0]  m_ovch;

   outputc_nvc #(.NVC(4), .VCHW(2), .DATAW(64), .TYPE_LSB(62), .FIFOD(4), .PKTLEN(4), .MODE(0))
   u_vct (
      .clk(clk), .rst_(rst_), .idata(idata), .ivalid(ivalid), .ivch(ivch),
      .odata(odata0), .ovalid(ovalid0), .ovch(ovch0), .iack(iack), .ordy(ordy0),
      .ilck(ilck), .olck(olck0), .err(err0)
   );

   outputc_nvc #(.NVC(4), .VCHW(2), .DATAW(64), .TYPE_LSB(62), .FIFOD(4), .PKTLEN(4), .MODE(1))
   u_wh (
      .clk(clk), .rst_(rst_), .idata(idata), .ivalid(ivalid), .ivch(ivch),
      .odata(odata1), .ovalid(ovalid1), .ovch(ovch1), .iack(iack), .ordy(ordy1),
      .ilck(ilck), .olck(olck1), .err(err1)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [3:0] exp_ordy(input int mode);
      logic [3:0] r;
      for (int v = 0; v < 4; v++) r[v] = (4 - m_cnt[v]) >= ((mode == 0) ? 4 : 1);
      return r;
   endfunction

   function automatic logic [3:0] exp_olck();
      logic [3:0] r;
      for (int v = 0; v < 4; v++) r[v] = m_olck[v];
      return r;
   endfunction

   task automatic model_reset();
      for (int v = 0; v < 4; v++) begin
         m_cnt[v] = 0; m_open[v] = 0; m_olck[v] = 0;
      end
      m_err = 3'b000; m_odata = '0; m_ovalid = 0; m_ovch = 2'd0;
   endtask

   // Applies the stage's rules to the inputs present at the clock edge.
   task automatic model_step();
      logic [1:0] ty;
      bit snd;
      int n_cnt[4];
      bit n_open[4], n_olck[4];
      ty = idata[63:62];
      for (int v = 0; v < 4; v++) begin
         snd = ivalid && (int'(ivch) == v);
         n_cnt[v] = m_cnt[v];
         n_open[v] = m_open[v];
         if (snd && !iack[v]) begin
            if (m_cnt[v] == 4) m_err[0] = 1'b1;
            else n_cnt[v] = m_cnt[v] + 1;
         end else if (iack[v] && !snd) begin
            if (m_cnt[v] == 0) m_err[1] = 1'b1;
            else n_cnt[v] = m_cnt[v] - 1;
         end
         if (snd) begin
            if ((ty == T_HEAD || ty == T_SINGLE) && m_open[v]) m_err[2] = 1'b1;
            if ((ty == T_BODY || ty == T_TAIL) && !m_open[v]) m_err[2] = 1'b1;
            if (ty == T_HEAD) n_open[v] = 1;
            if (ty == T_TAIL) n_open[v] = 0;
         end
         if (snd || (m_ovalid && int'(m_ovch) == v)) n_olck[v] = 1;
         else if (m_open[v]) n_olck[v] = 1;
         else if (m_olck[v] && !ilck[v]) n_olck[v] = 0;
         else n_olck[v] = m_olck[v];
      end
      for (int v = 0; v < 4; v++) begin
         m_cnt[v] = n_cnt[v]; m_open[v] = n_open[v]; m_olck[v] = n_olck[v];
      end
      m_odata = ivalid ? idata : '0;
      m_ovalid = ivalid;
      m_ovch = ivalid ? ivch : 2'd0;
   endtask

   // Drives one cycle of stimulus, advances the model, returns #1 after the edge.
   task automatic drive(input logic v, input logic [1:0] ch, input logic [1:0] ty,
                        input logic [3:0] ack, input logic [3:0] lk);
      idata = {ty, 30'($urandom), 32'($urandom)};
      ivalid = v; ivch = ch; iack = ack; ilck = lk;
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic idle_inputs();
      idata = '0; ivalid = 0; ivch = 2'd0; iack = 4'd0; ilck = 4'd0;
   endtask

   task automatic do_reset();
      idle_inputs();
      @(negedge clk);
      rst_ = 1'b1;
      @(negedge clk);
      rst_ = 1'b0;
      model_reset();
   endtask

   task automatic test_reset();
      idle_inputs();
      #12;
      checks++; if (ordy0 !== 4'b1111 || ordy1 !== 4'b1111) begin
         errors++; $display("FAIL rst_ordy_in_reset got %b/%b want 1111", ordy0, ordy1); end
      @(negedge clk); rst_ = 1'b0; model_reset();
      drive(0, 2'd0, T_SINGLE, 4'd0, 4'd0);
      checks++; if (ordy0 !== 4'b1111 || olck0 !== 4'b0000 || ovalid0 !== 1'b0 || err0 !== 3'b000) begin
         errors++; $display("FAIL rst_idle got ordy=%b olck=%b ovalid=%b err=%b want 1111 0000 0 000",
                            ordy0, olck0, ovalid0, err0); end
      drive(1, 2'd1, T_HEAD, 4'b0001, 4'd0);
      checks++; if (ovalid0 !== 1'b1 || olck0 !== 4'b0010 || err0 !== 3'b010) begin
         errors++; $display("FAIL rst_prep got ovalid=%b olck=%b err=%b want 1 0010 010",
                            ovalid0, olck0, err0); end
      idle_inputs();
      #3 rst_ = 1'b1;
      #1;
      checks++; if (ovalid0 !== 1'b0 || odata0 !== 64'd0 || olck0 !== 4'b0000 || err0 !== 3'b000 ||
                    ordy0 !== 4'b1111 || ovalid1 !== 1'b0 || olck1 !== 4'b0000) begin
         errors++; $display("FAIL rst_async got ovalid=%b odata=%h olck=%b err=%b ordy=%b want 0 0 0000 000 1111",
                            ovalid0, odata0, olck0, err0, ordy0); end
      @(negedge clk); rst_ = 1'b0; model_reset();
   endtask

   task automatic test_vct();
      logic [1:0] seq[4] = '{T_HEAD, T_BODY, T_BODY, T_TAIL};
      logic [63:0] sent;
      do_reset();
      for (int i = 0; i < 4; i++) begin
         drive(1, 2'd2, seq[i], 4'd0, 4'd0);
         sent = idata;
         checks++; if (odata0 !== sent || ovalid0 !== 1'b1 || ovch0 !== 2'd2) begin
            errors++; $display("FAIL vct_out i=%0d got %h/%b/%0d want %h/1/2", i, odata0, ovalid0, ovch0, sent); end
         checks++; if (ordy0[2] !== 1'b0 || ordy0 !== exp_ordy(0)) begin
            errors++; $display("FAIL vct_ordy_drop i=%0d got %b want %b", i, ordy0, exp_ordy(0)); end
      end
      for (int a = 1; a <= 4; a++) begin
         drive(0, 2'd0, T_SINGLE, 4'b0100, 4'd0);
         checks++; if (ordy0[2] !== (a == 4) || ordy0 !== exp_ordy(0)) begin
            errors++; $display("FAIL vct_ack a=%0d got %b want %b", a, ordy0, exp_ordy(0)); end
      end
      checks++; if (ovalid0 !== 1'b0 || odata0 !== 64'd0) begin
         errors++; $display("FAIL vct_idle_out got %b/%h want 0/0", ovalid0, odata0); end
   endtask

   task automatic test_wormhole();
      logic [1:0] seq[4] = '{T_HEAD, T_BODY, T_BODY, T_TAIL};
      do_reset();
      for (int i = 0; i < 4; i++) begin
         drive(1, 2'd2, seq[i], 4'd0, 4'd0);
         checks++; if (ordy1[2] !== (i != 3) || ordy1 !== exp_ordy(1)) begin
            errors++; $display("FAIL wh_ordy i=%0d got %b want %b", i, ordy1, exp_ordy(1)); end
      end
      drive(0, 2'd0, T_SINGLE, 4'b0100, 4'd0);
      checks++; if (ordy1[2] !== 1'b1) begin
         errors++; $display("FAIL wh_ack got %b want 1", ordy1[2]); end
   endtask

   task automatic test_lock();
      logic [1:0] seq[4] = '{T_HEAD, T_BODY, T_BODY, T_TAIL};
      do_reset();
      for (int i = 0; i < 4; i++) begin
         drive(1, 2'd1, seq[i], 4'd0, 4'b0010);
         checks++; if (olck0[1] !== 1'b1) begin
            errors++; $display("FAIL lock_pkt i=%0d got %b want 1", i, olck0[1]); end
      end
      for (int i = 0; i < 3; i++) begin
         drive(0, 2'd0, T_SINGLE, 4'd0, 4'b0010);
         checks++; if (olck0[1] !== 1'b1 || olck1 !== exp_olck()) begin
            errors++; $display("FAIL lock_hold i=%0d got %b want %b", i, olck0, exp_olck()); end
      end
      drive(0, 2'd0, T_SINGLE, 4'd0, 4'd0);
      checks++; if (olck0[1] !== 1'b0) begin
         errors++; $display("FAIL lock_release got %b want 0", olck0[1]); end
      drive(1, 2'd0, T_SINGLE, 4'd0, 4'd0);
      checks++; if (olck0[0] !== 1'b1) begin
         errors++; $display("FAIL single_c1 got %b want 1", olck0[0]); end
      drive(0, 2'd0, T_SINGLE, 4'd0, 4'd0);
      checks++; if (olck0[0] !== 1'b1) begin
         errors++; $display("FAIL single_c2 got %b want 1", olck0[0]); end
      drive(0, 2'd0, T_SINGLE, 4'd0, 4'd0);
      checks++; if (olck0[0] !== 1'b0 || err0 !== 3'b000) begin
         errors++; $display("FAIL single_c3 got olck=%b err=%b want 0 000", olck0[0], err0); end
   endtask

   task automatic test_simultaneous();
      do_reset();
      drive(1, 2'd3, T_HEAD, 4'd0, 4'd0);
      drive(1, 2'd3, T_BODY, 4'd0, 4'd0);
      drive(1, 2'd3, T_BODY, 4'b1000, 4'd0);
      checks++; if (ordy1[3] !== 1'b1 || ordy0[3] !== 1'b0 || m_cnt[3] != 2) begin
         errors++; $display("FAIL sim_cnt2 got %b/%b want 1/0", ordy1[3], ordy0[3]); end
      drive(0, 2'd0, T_SINGLE, 4'b0001, 4'd0);
      checks++; if (err0 !== 3'b010 || err1 !== 3'b010 || ordy0[0] !== 1'b1) begin
         errors++; $display("FAIL sim_underflow got %b/%b want 010", err0, err1); end
      drive(1, 2'd3, T_BODY, 4'd0, 4'd0);
      drive(1, 2'd3, T_BODY, 4'd0, 4'd0);
      checks++; if (ordy1[3] !== 1'b0 || err0 !== 3'b010) begin
         errors++; $display("FAIL sim_full got ordy=%b err=%b want 0 010", ordy1[3], err0); end
      drive(1, 2'd3, T_BODY, 4'd0, 4'd0);
      checks++; if (err0 !== 3'b011 || err1 !== 3'b011) begin
         errors++; $display("FAIL sim_overflow got %b/%b want 011", err0, err1); end
      drive(0, 2'd0, T_SINGLE, 4'b1000, 4'd0);
      checks++; if (ordy1[3] !== 1'b1) begin
         errors++; $display("FAIL sim_ovf_hold got %b want 1", ordy1[3]); end
      for (int a = 0; a < 3; a++) drive(0, 2'd0, T_SINGLE, 4'b1000, 4'd0);
      checks++; if (ordy0[3] !== 1'b1 || err0 !== 3'b011) begin
         errors++; $display("FAIL sim_drain got ordy=%b err=%b want 1 011", ordy0[3], err0); end
   endtask

   task automatic test_protocol();
      do_reset();
      drive(1, 2'd0, T_BODY, 4'd0, 4'd0);
      checks++; if (err0 !== 3'b100 || err1 !== 3'b100) begin
         errors++; $display("FAIL proto_body got %b/%b want 100", err0, err1); end
      do_reset();
      drive(1, 2'd1, T_HEAD, 4'd0, 4'd0);
      checks++; if (err0 !== 3'b000) begin
         errors++; $display("FAIL proto_head1 got %b want 000", err0); end
      drive(1, 2'd1, T_HEAD, 4'd0, 4'd0);
      checks++; if (err0 !== 3'b100 || olck0[1] !== 1'b1) begin
         errors++; $display("FAIL proto_head2 got err=%b olck=%b want 100 1", err0, olck0[1]); end
      drive(0, 2'd0, T_SINGLE, 4'd0, 4'd0);
      drive(0, 2'd0, T_SINGLE, 4'd0, 4'd0);
      checks++; if (olck0[1] !== 1'b1) begin
         errors++; $display("FAIL proto_lock_held got %b want 1", olck0[1]); end
   endtask

   task automatic test_random();
      logic [1:0] ch, ty;
      logic [3:0] ack, lk;
      logic v;
      do_reset();
      for (int c = 0; c < 400; c++) begin
         v = ($urandom_range(0, 9) < 6);
         ch = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 19) == 0) ty = 2'($urandom_range(0, 3));
         else if (m_open[ch]) ty = ($urandom_range(0, 2) == 0) ? T_TAIL : T_BODY;
         else ty = ($urandom_range(0, 1) == 1) ? T_HEAD : T_SINGLE;
         for (int k = 0; k < 4; k++) begin
            ack[k] = (m_cnt[k] > 0 && $urandom_range(0, 2) == 0) || ($urandom_range(0, 49) == 0);
            lk[k] = ($urandom_range(0, 3) == 0);
         end
         drive(v, ch, ty, ack, lk);
         checks++; if (odata0 !== m_odata || ovalid0 !== m_ovalid || ovch0 !== m_ovch ||
                       odata1 !== m_odata || ovalid1 !== m_ovalid || ovch1 !== m_ovch) begin
            errors++; $display("FAIL rnd_out c=%0d got %h/%b/%0d want %h/%b/%0d",
                               c, odata0, ovalid0, ovch0, m_odata, m_ovalid, m_ovch); end
         checks++; if (ordy0 !== exp_ordy(0) || ordy1 !== exp_ordy(1)) begin
            errors++; $display("FAIL rnd_ordy c=%0d got %b/%b want %b/%b",
                               c, ordy0, ordy1, exp_ordy(0), exp_ordy(1)); end
         checks++; if (olck0 !== exp_olck() || olck1 !== exp_olck()) begin
            errors++; $display("FAIL rnd_olck c=%0d got %b/%b want %b", c, olck0, olck1, exp_olck()); end
         checks++; if (err0 !== m_err || err1 !== m_err) begin
            errors++; $display("FAIL rnd_err c=%0d got %b/%b want %b", c, err0, err1, m_err); end
      end
   endtask

   initial begin
      rst_ = 1'b1;
      idle_inputs();
      model_reset();
      test_reset();
      test_vct();
      test_wormhole();
      test_lock();
      test_simultaneous();
      test_protocol();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
